wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; TIMEOUT_CYCLES, 64, watchdog limit (legal range 1..255).
REQ-002 Ports SHALL be (name, direction, width, meaning): clk_i, in, 1, clock; rst_i, in, 1, reset, synchronous and active-high.
REQ-003 For each master mX, X in {0,1}, the inputs SHALL be: mX_cyc_i, in, 1, cycle; mX_stb_i, in, 1, strobe; mX_we_i, in, 1, write enable; mX_adr_i, in, ADDR_WIDTH, address; mX_dat_i, in, DATA_WIDTH, write data; mX_sel_i, in, DATA_WIDTH/8, byte select.
REQ-004 For each master mX, the outputs SHALL be: mX_dat_o, out, DATA_WIDTH, read data; mX_ack_o, out, 1, acknowledge; mX_err_o, out, 1, timeout error.
REQ-005 Slave-side ports SHALL be: CYC_O, STB_O, WE_O, out, 1 each; ADR_O, out, ADDR_WIDTH; DAT_O, out, DATA_WIDTH; SEL_O, out, DATA_WIDTH/8; DAT_I, in, DATA_WIDTH; ACK_I, in, 1.

Function
REQ-006 The FSM SHALL have states IDLE, GNT0, GNT1 and ERR; ERR exists only with the macro defined.
REQ-007 In IDLE, if exactly one mX_cyc_i is high, the next state SHALL be GNTX.
REQ-008 In IDLE, if both mX_cyc_i are high, the arbiter SHALL grant the master opposite to register last_gnt, then set last_gnt to the granted index.
REQ-009 The grant latency SHALL be one cycle: a request sampled in IDLE at edge N makes the slave bus driven from cycle N+1.
REQ-010 In GNTX, the arbiter SHALL drive CYC_O=mX_cyc_i, STB_O=mX_stb_i&mX_cyc_i, and WE_O/ADR_O/DAT_O/SEL_O from mX, combinationally.
REQ-011 In IDLE, all slave-side outputs SHALL be 0.
REQ-012 mX_ack_o SHALL be ACK_I only while in GNTX, and 0 otherwise.
REQ-013 mX_dat_o SHALL be DAT_I while in GNTX, and 0 otherwise.
REQ-014 The non-granted master SHALL see ack=0, err=0 and dat=0.
REQ-015 In GNTX, when mX_cyc_i is low, the next state SHALL be IDLE.
REQ-016 At least one IDLE cycle SHALL separate consecutive grants, so that a registered-ACK slave can drop ACK and return to its idle state.
REQ-017 Grant SHALL NOT change while mX_cyc_i remains high: no preemption, including across multiple strobes inside one CYC.
REQ-018 A request that arrives while the other master is granted SHALL wait, and is served at the next IDLE ahead of a re-request by the just-served master.

Reset
REQ-019 While rst_i is high at a clock edge, the state SHALL become IDLE, last_gnt SHALL become 1 (m0 wins the first tie), and the watchdog counter SHALL become 0.
REQ-020 All outputs SHALL be 0 in the cycle after reset.
REQ-021 Reset during GNTX SHALL abandon the transfer with no ACK or ERR generated; a master still holding CYC is re-arbitrated normally afterwards.

Configuration
REQ-022 Macro WB_ARB_TIMEOUT_EN SHALL enable an 8-bit watchdog counter.
REQ-023 With the macro defined, in GNTX the counter SHALL increment each cycle that STB_O=1 and ACK_I=0, and clear on ACK_I=1 or on leaving GNTX.
REQ-024 With the macro defined, on the cycle the counter equals TIMEOUT_CYCLES the next state SHALL be ERR.
REQ-025 In ERR, CYC_O and STB_O SHALL be 0, mX_err_o SHALL be 1 for the timed-out master, and the state SHALL return to IDLE when that master's mX_cyc_i is low.
REQ-026 An ACK_I arriving in the same cycle the limit is reached SHALL win: the transfer is acknowledged and no ERR occurs.
REQ-027 Without the macro, there SHALL be no counter and no ERR state, and mX_err_o SHALL be tied 0; the ports remain present.

Verification
REQ-028 After reset, raise m0 and m1 cyc/stb in the same cycle -> m0 is granted at N+1; after m0 drops CYC, one IDLE cycle, then GNT1.
REQ-029 m1 issues a write with adr=0x10, dat=0xDEADBEEF, sel=0xF -> ADR_O/DAT_O/SEL_O/WE_O match; m1_ack_o follows ACK_I; m0_ack_o stays 0.
REQ-030 m0 issues three back-to-back reads under one CYC while m1 requests -> no grant change until m0 drops CYC; m1 is granted afterwards.
REQ-031 Assert rst_i during GNT0 mid-read with ACK_I not yet seen -> IDLE next cycle, all outputs 0, no ack.
REQ-032 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ACK_I held 0 -> m0_err_o=1 after 4 stalled cycles; CYC_O=0; IDLE once m0 drops CYC.
REQ-033 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ACK_I rises on the 4th stalled cycle -> ack delivered and err remains 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with a round-robin tie-break and a non-preemptive grant.
// Define WB_ARB_TIMEOUT_EN to add the stalled-transfer watchdog and the ERR state.
module wb_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,

    output logic                    CYC_O,
    output logic                    STB_O,
    output logic                    WE_O,
    output logic [ADDR_WIDTH-1:0]   ADR_O,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    output logic [DATA_WIDTH/8-1:0] SEL_O,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    input  logic                    ACK_I
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] ERR  = 2'd3;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0] state_q, state_d;
    logic       last_gnt_q, last_gnt_d;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       granted;
    logic       stall;
    logic       timeout_hit;
    logic       err_cyc;

    assign granted = (state_q == GNT0) || (state_q == GNT1);
    assign stall   = granted && STB_O && !ACK_I;
    // The stall now in progress is the one that reaches the limit; a same-cycle ACK wins.
    assign timeout_hit = stall && (wdog_q == TIMEOUT_LAST);
    assign err_cyc     = last_gnt_q ? m1_cyc_i : m0_cyc_i;

    always_comb begin
        wdog_d = wdog_q;
        if (!granted || ACK_I || (state_d != state_q)) begin
            wdog_d = '0;
        end else if (stall) begin
            wdog_d = wdog_q + 8'd1;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d    = last_gnt_q ? GNT0 : GNT1;
                    last_gnt_d = ~last_gnt_q;
                end else if (m0_cyc_i) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ERR;
`endif
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ERR;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ERR: begin
                if (!err_cyc) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    // Slave bus and responses follow the granted master combinationally.
    always_comb begin
        CYC_O    = 1'b0;
        STB_O    = 1'b0;
        WE_O     = 1'b0;
        ADR_O    = '0;
        DAT_O    = '0;
        SEL_O    = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        case (state_q)
            GNT0: begin
                CYC_O    = m0_cyc_i;
                STB_O    = m0_stb_i & m0_cyc_i;
                WE_O     = m0_we_i;
                ADR_O    = m0_adr_i;
                DAT_O    = m0_dat_i;
                SEL_O    = m0_sel_i;
                m0_dat_o = DAT_I;
                m0_ack_o = ACK_I;
            end
            GNT1: begin
                CYC_O    = m1_cyc_i;
                STB_O    = m1_stb_i & m1_cyc_i;
                WE_O     = m1_we_i;
                ADR_O    = m1_adr_i;
                DAT_O    = m1_dat_i;
                SEL_O    = m1_sel_i;
                m1_dat_o = DAT_I;
                m1_ack_o = ACK_I;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    assign m0_err_o = (state_q == ERR) && !last_gnt_q;
    assign m1_err_o = (state_q == ERR) &&  last_gnt_q;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule
